// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO burst reader.
package fifo_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer; an arriving word falls straight through when the buffer is empty.
module stream_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         have_word;
  logic         push;
  logic         pop;

  assign have_word = (count != 2'd0);
  assign out_valid = have_word || in_valid;
  assign out_data  = have_word ? mem[rd_ptr] : (in_valid ? in_data : '0);

  // Store the arriving word unless it is consumed directly in the cycle it arrives.
  assign push = in_valid && !(!have_word && out_ready);
  assign pop  = have_word && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a burst of i_len words from a sync FIFO and streams them out with valid/ready and last.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for i_start; latches i_len into pops_left
// ST_RUN   | issuing pops while the buffer has room
// ST_DRAIN | all pops issued; waiting for the word marked last to leave
// ST_DONE  | one-cycle o_done, then back to idle
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fifo_rd_incr,
  input  logic [WIDTH-1:0] i_fifo_data,
  input  logic             i_fifo_empty,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  input  logic             i_ready
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] pops_left;
  logic             in_flight;
  logic             in_flight_last;
  logic             pop;
  logic             last_pop;
  logic [1:0]       buf_count;
  logic [2:0]       occupancy;
  logic             buf_valid;
  logic [WIDTH:0]   buf_data;

  assign occupancy = {1'b0, buf_count} + {2'b00, in_flight};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      pops_left      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      state          <= state_nxt;
      in_flight      <= pop;
      in_flight_last <= last_pop;
      if (state == ST_IDLE && i_start) begin
        pops_left <= i_len;
      end else if (pop) begin
        pops_left <= pops_left - LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    last_pop       = 1'b0;
    o_busy         = (state != ST_IDLE);
    o_done         = 1'b0;
    o_fifo_rd_incr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = (i_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        pop            = !i_fifo_empty && (pops_left != '0) && (occupancy < 3'd2);
        last_pop       = pop && (pops_left == LEN_W'(1));
        o_fifo_rd_incr = pop;
        if (last_pop) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (o_valid && i_ready && o_last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The word popped last cycle arrives on i_fifo_data now, tagged with its last flag.
  stream_skid_buf #(
    .W(WIDTH + 1)
  ) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .in_valid  (in_flight),
    .in_data   ({in_flight_last, i_fifo_data}),
    .out_ready (i_ready),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .count     (buf_count)
  );

  assign o_valid = buf_valid;
  assign o_data  = buf_data[WIDTH-1:0];
  assign o_last  = buf_valid && buf_data[WIDTH];

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural sync FIFO on the read side.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        wr_en = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [15:0] wr_data = 16'd0;
  logic [15:0] fifo_data = 16'd0;
  logic        fifo_empty = 1'b1;
  logic        busy, done, rd_incr, valid, last;
  logic [15:0] data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(16), .LEN_W(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_len          (len),
    .o_busy         (busy),
    .o_done         (done),
    .o_fifo_rd_incr (rd_incr),
    .i_fifo_data    (fifo_data),
    .i_fifo_empty   (fifo_empty),
    .o_valid        (valid),
    .o_data         (data),
    .o_last         (last),
    .i_ready        (ready)
  );

  logic [15:0] fq[$];

  always @(posedge clk) begin : fifo_model
    int n;
    if (flush) fq.delete();
    n = fq.size();
    if (rd_incr && n > 0) begin
      fifo_data <= fq.pop_front();
      n = n - 1;
    end
    if (wr_en) begin
      fq.push_back(wr_data);
      n = n + 1;
    end
    fifo_empty <= (n == 0);
  end

  always @(posedge clk) cyc <= cyc + 1;

  int busy_cnt = 0, done_cnt = 0, pop_cnt = 0, out_cnt = 0;
  int over_cnt = 0, hold_viol = 0, gap_cnt = 0, done_cyc = 0;
  logic        prev_stall = 1'b0;
  logic        prev_last = 1'b0;
  logic [15:0] prev_data = 16'd0;
  logic [15:0] rx_data[$];
  logic        rx_last[$];
  int          rx_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      out_cnt    <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (rd_incr) pop_cnt <= pop_cnt + 1;
      if (valid && ready) begin
        rx_data.push_back(data);
        rx_last.push_back(last);
        rx_cyc.push_back(cyc);
      end
      out_cnt <= out_cnt + int'(rd_incr) - int'(valid && ready);
      if (out_cnt + int'(rd_incr) - int'(valid && ready) > 2) over_cnt <= over_cnt + 1;
      if (prev_stall && (!valid || data != prev_data || last != prev_last)) hold_viol <= hold_viol + 1;
      if (busy && !valid) gap_cnt <= gap_cnt + 1;
      prev_stall <= valid && !ready;
      prev_data  <= data;
      prev_last  <= last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_words(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + 16'(i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start     = 1'b1;
    len       = l;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input bit toggle);
    int n = 0;
    while (done_cnt == base && n < 200) begin
      if (toggle) ready = ~ready;
      tick();
      n++;
    end
    ready = 1'b1;
    check("done_timeout", 32'(done_cnt != base), 32'd1);
  endtask

  task automatic check_burst(input string tag, input int base, input logic [15:0] first,
                             input int n, input int total);
    check({tag, "_count"}, 32'(rx_data.size() - base), 32'(total));
    for (int i = 0; i < n; i++) begin
      if (base + i < rx_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), 32'(rx_data[base + i]), 32'(first + 16'(i)));
        check($sformatf("%s_last%0d", tag, i), 32'(rx_last[base + i]), 32'(i == n - 1));
      end
    end
  endtask

  int b_rx, b_done, b_pop, b_busy, b_hold, b_over, b_gap, n_wait;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_rd_incr", 32'(rd_incr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    rst = 1'b0;
    tick();

    // basic 4-word burst, ready always high
    push_words(16'h0001, 4);
    b_rx = rx_data.size(); b_done = done_cnt;
    pulse_start(8'd4);
    wait_done(b_done, 1'b0);
    tick(); tick();
    check_burst("t1", b_rx, 16'h0001, 4, 4);
    check("t1_first_rel", 32'(rx_cyc[b_rx] - start_cyc), 32'd2);
    check("t1_last_rel", 32'(rx_cyc[b_rx + 3] - start_cyc), 32'd5);
    check("t1_done_rel", 32'(done_cyc - start_cyc), 32'd6);
    check("t1_done_count", 32'(done_cnt - b_done), 32'd1);

    // zero-length burst with data available
    push_words(16'h0099, 1);
    b_pop = pop_cnt; b_busy = busy_cnt; b_done = done_cnt;
    pulse_start(8'd0);
    wait_done(b_done, 1'b0);
    tick();
    check("t2_pops", 32'(pop_cnt - b_pop), 32'd0);
    check("t2_done_rel", 32'(done_cyc - start_cyc), 32'd1);
    check("t2_busy_cycles", 32'(busy_cnt - b_busy), 32'd1);
    do_flush();

    // ready toggling every cycle
    push_words(16'h0010, 6);
    b_rx = rx_data.size(); b_done = done_cnt; b_hold = hold_viol; b_over = over_cnt;
    pulse_start(8'd6);
    wait_done(b_done, 1'b1);
    tick(); tick();
    check_burst("t3", b_rx, 16'h0010, 6, 6);
    check("t3_hold_viol", 32'(hold_viol - b_hold), 32'd0);
    check("t3_outstanding_over2", 32'(over_cnt - b_over), 32'd0);

    // FIFO runs dry after two words, refilled later
    push_words(16'h0021, 2);
    b_rx = rx_data.size(); b_done = done_cnt; b_gap = gap_cnt;
    pulse_start(8'd5);
    repeat (9) tick();
    push_words(16'h0023, 3);
    wait_done(b_done, 1'b0);
    tick(); tick();
    check_burst("t4", b_rx, 16'h0021, 5, 5);
    check("t4_stall_seen", 32'((gap_cnt - b_gap) >= 5), 32'd1);

    // reset mid-burst, then a fresh 2-word burst
    push_words(16'h0031, 8);
    b_rx = rx_data.size();
    pulse_start(8'd8);
    n_wait = 0;
    while (rx_data.size() - b_rx < 3 && n_wait < 50) begin
      tick();
      n_wait++;
    end
    check("t5_three_words", 32'(rx_data.size() - b_rx >= 3), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_last", 32'(last), 32'd0);
    check("t5_rd_incr", 32'(rd_incr), 32'd0);
    check("t5_data", 32'(data), 32'd0);
    rst = 1'b0;
    do_flush();
    push_words(16'h00A1, 2);
    b_rx = rx_data.size(); b_done = done_cnt;
    pulse_start(8'd2);
    wait_done(b_done, 1'b0);
    tick(); tick();
    check_burst("t5_after", b_rx, 16'h00A1, 2, 2);
    check("t5_done_count", 32'(done_cnt - b_done), 32'd1);

    // start pulsed again while busy is ignored
    push_words(16'h0041, 5);
    b_rx = rx_data.size(); b_done = done_cnt; b_pop = pop_cnt;
    pulse_start(8'd3);
    start = 1'b1;
    len   = 8'd7;
    tick();
    start = 1'b0;
    wait_done(b_done, 1'b0);
    repeat (6) tick();
    check_burst("t6", b_rx, 16'h0041, 3, 3);
    check("t6_done_count", 32'(done_cnt - b_done), 32'd1);
    check("t6_pops", 32'(pop_cnt - b_pop), 32'd3);
    do_flush();

    // back-to-back bursts: start in the cycle right after DONE
    push_words(16'h0051, 3);
    b_rx = rx_data.size(); b_done = done_cnt;
    pulse_start(8'd1);
    wait_done(b_done, 1'b0);
    pulse_start(8'd2);
    wait_done(b_done + 1, 1'b0);
    tick(); tick();
    check_burst("t7a", b_rx, 16'h0051, 1, 3);
    check_burst("t7b", b_rx + 1, 16'h0052, 2, 2);
    check("t7_second_first_rel", 32'(rx_cyc[b_rx + 1] - start_cyc), 32'd2);
    check("t7_done_count", 32'(done_cnt - b_done), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
